// File: rtl/tile_map_pkg.sv
// Shared types and the pixel-to-tile helper for the scrolling tile map window.
package tile_map_pkg;

  localparam int PIX_W      = 10;
  localparam int ID_W_DFLT  = 3;
  localparam int TILE_EMPTY = 0;

  typedef logic [ID_W_DFLT-1:0] tile_id_t;

  typedef enum logic [1:0] {FILL, IDLE, FETCH} state_e;

  typedef struct packed {
    logic             hit;
    logic [PIX_W-1:0] tx;
    logic [PIX_W-1:0] ty;
  } tile_pos_t;

  // Pixel left/above the origin or past the window edge reports a miss.
  function automatic tile_pos_t pix_to_tile(
    input logic [PIX_W-1:0] px,
    input logic [PIX_W-1:0] py,
    input int               org_x,
    input int               org_y,
    input int               tile_px,
    input int               cols,
    input int               rows
  );
    tile_pos_t pos;
    int        tx;
    int        ty;
    tx      = (int'(px) - org_x) / tile_px;
    ty      = (int'(py) - org_y) / tile_px;
    pos.hit = (int'(px) >= org_x) && (int'(py) >= org_y) && (tx < cols) && (ty < rows);
    pos.tx  = PIX_W'(tx);
    pos.ty  = PIX_W'(ty);
    return pos;
  endfunction

endpackage

// File: rtl/tile_lookup.sv
// One registered pixel -> tile ID lookup channel over the circular slot array.
// Latency 1 cycle; reads the array as it stood before the same edge's writes.
module tile_lookup
  import tile_map_pkg::*;
#(
  parameter int COLS     = 10,
  parameter int ROWS     = 10,
  parameter int ID_W     = 3,
  parameter int TILE_PX  = 40,
  parameter int ORIGIN_X = 120,
  parameter int ORIGIN_Y = 40,
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [PIX_W-1:0]          i_px,
  input  logic [PIX_W-1:0]          i_py,
  input  logic [COLS*ROWS*ID_W-1:0] i_slots,
  input  logic [CW-1:0]             i_head,
  output logic [ID_W-1:0]           o_id
);

  tile_pos_t       w_pos;
  int              w_slot;
  int              w_idx;
  logic [ID_W-1:0] w_id;
  logic [ID_W-1:0] r_id;

  always_comb begin
    w_pos  = pix_to_tile(i_px, i_py, ORIGIN_X, ORIGIN_Y, TILE_PX, COLS, ROWS);
    w_slot = int'(i_head) + int'(w_pos.tx);
    if (w_slot >= COLS) w_slot = w_slot - COLS;
    w_idx  = w_pos.hit ? (w_slot * ROWS + int'(w_pos.ty)) : 0;
    w_id   = w_pos.hit ? i_slots[w_idx*ID_W +: ID_W] : ID_W'(TILE_EMPTY);
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_id <= '0;
    else       r_id <= w_id;
  end

  assign o_id = r_id;

endmodule

// File: rtl/tile_map_window.sv
// Scrolling COLS x ROWS tile window: circular slot buffer filled/scrolled from level memory,
// one draw lookup plus NUM_PROBES probe lookups per cycle, and a single tile overwrite port.
module tile_map_window
  import tile_map_pkg::*;
#(
  parameter int COLS       = 10,
  parameter int ROWS       = 10,
  parameter int ID_W       = 3,
  parameter int NUM_PROBES = 6,
  parameter int TILE_PX    = 40,
  parameter int ORIGIN_X   = 120,
  parameter int ORIGIN_Y   = 40,
  parameter int MAP_COL_W  = 8,
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        scroll_req,
  output logic                        busy,
  output logic [MAP_COL_W-1:0]        base_col,
  output logic                        col_req,
  output logic [MAP_COL_W-1:0]        col_addr,
  input  logic                        col_valid,
  input  logic [ROWS*ID_W-1:0]        col_data,
  input  logic [PIX_W-1:0]            draw_x,
  input  logic [PIX_W-1:0]            draw_y,
  output logic [ID_W-1:0]             draw_id,
  input  logic [NUM_PROBES*PIX_W-1:0] probe_x,
  input  logic [NUM_PROBES*PIX_W-1:0] probe_y,
  output logic [NUM_PROBES*ID_W-1:0]  probe_id,
  input  logic                        wr_en,
  input  logic [CW-1:0]               wr_col,
  input  logic [RW-1:0]               wr_row,
  input  logic [ID_W-1:0]             wr_id
);

  state_e                    r_state, w_state_nxt;
  logic [CW-1:0]             r_head, w_head_nxt;
  logic [CW-1:0]             r_fill_cnt, w_fill_nxt;
  logic [MAP_COL_W-1:0]      r_base_col, w_base_nxt;
  logic [MAP_COL_W-1:0]      r_col_addr, w_addr_nxt;
  logic                      r_col_req, w_req_nxt;
  logic                      w_xfer;
  logic                      w_commit;
  logic [CW-1:0]             w_commit_slot;
  logic [CW:0]               w_wr_sum;
  logic [CW-1:0]             w_wr_slot;
  logic                      w_wr_ok;
  logic [COLS*ROWS*ID_W-1:0] r_slots;

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_xfer        = r_col_req & col_valid;
    w_state_nxt   = r_state;
    w_head_nxt    = r_head;
    w_fill_nxt    = r_fill_cnt;
    w_base_nxt    = r_base_col;
    w_addr_nxt    = r_col_addr;
    w_req_nxt     = r_col_req;
    w_commit      = 1'b0;
    w_commit_slot = r_head;
    case (r_state)
      FILL: begin
        // Request drops for one cycle after each transfer, then re-raises for the next column.
        w_addr_nxt    = MAP_COL_W'(r_fill_cnt);
        w_req_nxt     = ~w_xfer;
        w_commit_slot = r_fill_cnt;
        if (w_xfer) begin
          w_commit = 1'b1;
          if (r_fill_cnt == CW'(COLS - 1)) begin
            w_state_nxt = IDLE;
            w_fill_nxt  = '0;
            w_head_nxt  = '0;
            w_base_nxt  = '0;
            w_req_nxt   = 1'b0;
          end else begin
            w_fill_nxt = r_fill_cnt + CW'(1);
            w_addr_nxt = MAP_COL_W'(r_fill_cnt + CW'(1));
          end
        end
      end
      IDLE: begin
        if (scroll_req) begin
          w_state_nxt = FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_base_col + MAP_COL_W'(COLS);
        end
      end
      FETCH: begin
        if (w_xfer) begin
          w_commit    = 1'b1;
          w_head_nxt  = (r_head == CW'(COLS - 1)) ? '0 : r_head + CW'(1);
          w_base_nxt  = r_base_col + MAP_COL_W'(1);
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_head     <= '0;
      r_fill_cnt <= '0;
      r_base_col <= '0;
      r_col_addr <= '0;
      r_col_req  <= 1'b0;
    end else begin
      r_head     <= w_head_nxt;
      r_fill_cnt <= w_fill_nxt;
      r_base_col <= w_base_nxt;
      r_col_addr <= w_addr_nxt;
      r_col_req  <= w_req_nxt;
    end
  end

  // Overwrites address window columns, so rotate by the pre-edge head.
  always_comb begin
    w_wr_sum  = (CW+1)'(r_head) + (CW+1)'(wr_col);
    w_wr_slot = (w_wr_sum >= (CW+1)'(COLS)) ? CW'(w_wr_sum - (CW+1)'(COLS)) : CW'(w_wr_sum);
    w_wr_ok   = wr_en && (r_state != FILL) && (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
  end

  // Commit is assigned last so it overrides a same-edge overwrite of the same slot.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_slots <= '0;
    end else begin
      if (w_wr_ok)
        r_slots[(int'(w_wr_slot)*ROWS + int'(wr_row))*ID_W +: ID_W] <= wr_id;
      if (w_commit)
        r_slots[int'(w_commit_slot)*ROWS*ID_W +: ROWS*ID_W] <= col_data;
    end
  end

  assign busy     = (r_state != IDLE);
  assign base_col = r_base_col;
  assign col_req  = r_col_req;
  assign col_addr = r_col_addr;

  tile_lookup #(
    .COLS(COLS), .ROWS(ROWS), .ID_W(ID_W), .TILE_PX(TILE_PX),
    .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y)
  ) u_draw (
    .Clk(Clk), .Reset(Reset), .i_px(draw_x), .i_py(draw_y),
    .i_slots(r_slots), .i_head(r_head), .o_id(draw_id)
  );

  for (genvar p = 0; p < NUM_PROBES; p++) begin : g_probe
    tile_lookup #(
      .COLS(COLS), .ROWS(ROWS), .ID_W(ID_W), .TILE_PX(TILE_PX),
      .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y)
    ) u_probe (
      .Clk(Clk), .Reset(Reset),
      .i_px(probe_x[p*PIX_W +: PIX_W]), .i_py(probe_y[p*PIX_W +: PIX_W]),
      .i_slots(r_slots), .i_head(r_head), .o_id(probe_id[p*ID_W +: ID_W])
    );
  end

endmodule

// File: tb/tb_tile_map_window.sv
// Directed bench for tile_map_window; level memory returns every row = (column mod 8).
module tb_tile_map_window;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        scroll_req;
  logic        busy;
  logic [7:0]  base_col;
  logic        col_req;
  logic [7:0]  col_addr;
  logic        col_valid;
  logic [29:0] col_data;
  logic [9:0]  draw_x, draw_y;
  logic [2:0]  draw_id;
  logic [59:0] probe_x, probe_y;
  logic [17:0] probe_id;
  logic        wr_en;
  logic [3:0]  wr_col;
  logic [3:0]  wr_row;
  logic [2:0]  wr_id;
  logic [17:0] pexp;

  int n_pass  = 0;
  int n_total = 0;

  tile_map_window dut (
    .Clk(Clk), .Reset(Reset), .scroll_req(scroll_req), .busy(busy), .base_col(base_col),
    .col_req(col_req), .col_addr(col_addr), .col_valid(col_valid), .col_data(col_data),
    .draw_x(draw_x), .draw_y(draw_y), .draw_id(draw_id),
    .probe_x(probe_x), .probe_y(probe_y), .probe_id(probe_id),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_id(wr_id)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a request, answers after dly cycles with data for the requested column.
  task automatic serve(input int dly, input logic [7:0] exp_addr, input string tag);
    int n;
    n = 0;
    while (!col_req && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(col_req), 32'd1);
    check({tag, "_addr"}, 32'(col_addr), 32'(exp_addr));
    repeat (dly - 1) tick();
    col_valid = 1'b1;
    col_data  = {10{col_addr[2:0]}};
    tick();
    col_valid = 1'b0;
    check({tag, "_drop"}, 32'(col_req), 32'd0);
  endtask

  task automatic draw(input int x, input int y, input logic [2:0] exp, input string tag);
    draw_x = 10'(x);
    draw_y = 10'(y);
    tick();
    check(tag, 32'(draw_id), 32'(exp));
  endtask

  task automatic set_probe(input int p, input int x, input int y);
    probe_x[p*10 +: 10] = 10'(x);
    probe_y[p*10 +: 10] = 10'(y);
  endtask

  initial begin
    Reset = 1'b1; scroll_req = 1'b0; col_valid = 1'b0; col_data = '0;
    draw_x = '0; draw_y = '0; probe_x = '0; probe_y = '0;
    wr_en = 1'b0; wr_col = '0; wr_row = '0; wr_id = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_req", 32'(col_req), 32'd0);
    check("rst_addr", 32'(col_addr), 32'd0);
    check("rst_base", 32'(base_col), 32'd0);
    check("rst_draw", 32'(draw_id), 32'd0);
    check("rst_probe", 32'(probe_id), 32'd0);

    // Initial fill; window column 9 must read empty until its column lands.
    draw_x = 10'd480; draw_y = 10'd40;
    Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      serve(2, 8'(i), $sformatf("fill%0d", i));
      if (i == 0) check("fill_unloaded", 32'(draw_id), 32'd0);
      if (i == 8) check("fill_busy_mid", 32'(busy), 32'd1);
    end
    check("fill_busy_done", 32'(busy), 32'd0);
    check("fill_base", 32'(base_col), 32'd0);
    draw(120, 40, 3'd0, "fill_c0");
    draw(160, 40, 3'd1, "fill_c1");
    draw(480, 40, 3'd1, "fill_c9");

    // Single scroll, with a second scroll_req during FETCH that must be dropped.
    scroll_req = 1'b1; tick(); scroll_req = 1'b0;
    check("scr_req", 32'(col_req), 32'd1);
    check("scr_addr", 32'(col_addr), 32'd10);
    check("scr_busy", 32'(busy), 32'd1);
    scroll_req = 1'b1; tick(); scroll_req = 1'b0;
    tick();
    check("scr_hold_req", 32'(col_req), 32'd1);
    check("scr_hold_addr", 32'(col_addr), 32'd10);
    col_valid = 1'b1; col_data = {10{3'd2}}; tick(); col_valid = 1'b0;
    check("scr_drop", 32'(col_req), 32'd0);
    check("scr_base", 32'(base_col), 32'd1);
    check("scr_idle", 32'(busy), 32'd0);
    tick();
    check("scr_noqueue", 32'(col_req), 32'd0);
    draw(120, 40, 3'd1, "scr_c0");
    draw(480, 40, 3'd2, "scr_c9");

    // Eleven more scrolls: head passes through 0, base_col reaches 12.
    for (int k = 0; k < 11; k++) begin
      scroll_req = 1'b1; tick(); scroll_req = 1'b0;
      serve(1, 8'(11 + k), $sformatf("wrap%0d", k));
    end
    check("wrap_base", 32'(base_col), 32'd12);
    draw(120, 40, 3'd4, "wrap_c0");
    draw(160, 40, 3'd5, "wrap_c1");
    draw(480, 40, 3'd5, "wrap_c9");

    // Window bounds.
    draw(100, 40, 3'd0, "oor_left");
    draw(520, 40, 3'd0, "oor_right");
    draw(120, 39, 3'd0, "oor_top");
    draw(120, 440, 3'd0, "oor_bottom");
    draw(519, 439, 3'd5, "edge_draw_9_9");
    set_probe(0, 240, 120);
    set_probe(1, 159, 79);
    set_probe(2, 160, 80);
    set_probe(5, 519, 439);
    tick();
    pexp = '0;
    pexp[2:0]   = 3'd7;
    pexp[5:3]   = 3'd4;
    pexp[8:6]   = 3'd5;
    pexp[17:15] = 3'd5;
    check("probe_vec", 32'(probe_id), 32'(pexp));

    // Overwrite window (3,2): same edge reads old, next edge reads new.
    set_probe(3, 240, 80);
    tick();
    wr_en = 1'b1; wr_col = 4'd3; wr_row = 4'd2; wr_id = 3'd5;
    tick();
    wr_en = 1'b0;
    check("wr_old", 32'(probe_id[2:0]), 32'd7);
    tick();
    check("wr_new", 32'(probe_id[2:0]), 32'd5);
    check("wr_neighbor", 32'(probe_id[11:9]), 32'd7);

    // Overwrite of window column 0 coincident with the commit into the same slot.
    scroll_req = 1'b1; tick(); scroll_req = 1'b0;
    check("wc_addr", 32'(col_addr), 32'd22);
    col_valid = 1'b1; col_data = {10{col_addr[2:0]}};
    wr_en = 1'b1; wr_col = 4'd0; wr_row = 4'd0; wr_id = 3'd3;
    tick();
    col_valid = 1'b0; wr_en = 1'b0;
    check("wc_base", 32'(base_col), 32'd13);
    draw(480, 40, 3'd6, "wc_commit_wins");
    draw(120, 40, 3'd5, "wc_c0");

    // Reset while a fetch is outstanding.
    scroll_req = 1'b1; tick(); scroll_req = 1'b0;
    check("rf_req", 32'(col_req), 32'd1);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    check("rf_req_low", 32'(col_req), 32'd0);
    check("rf_addr", 32'(col_addr), 32'd0);
    check("rf_base", 32'(base_col), 32'd0);
    check("rf_busy", 32'(busy), 32'd1);
    check("rf_draw", 32'(draw_id), 32'd0);
    Reset = 1'b0;
    draw_x = 10'd120; draw_y = 10'd40;
    wr_en = 1'b1; wr_col = 4'd0; wr_row = 4'd0; wr_id = 3'd7;
    tick();
    wr_en = 1'b0;
    check("rf_refill_req", 32'(col_req), 32'd1);
    check("rf_refill_addr", 32'(col_addr), 32'd0);
    tick();
    check("rf_fill_wr_ignored", 32'(draw_id), 32'd0);
    serve(2, 8'd0, "refill0");
    serve(2, 8'd1, "refill1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
